// File: rtl/res_arb_if.sv
// Requester and result-memory signal bundle for res_arb.
// slave = arbiter side, master = requesters plus memory model side.
interface res_arb_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic          r0_req, r0_wr;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt, r0_rvalid;
  logic [DW-1:0] r0_rdata;

  logic          r1_req, r1_wr;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt, r1_rvalid;
  logic [DW-1:0] r1_rdata;

  logic          res_rd, res_wr;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_do, res_di;
  logic          idle;

  modport slave (
    input  r0_req, r0_wr, r0_addr, r0_wdata, r1_req, r1_wr, r1_addr, r1_wdata, res_di,
    output r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
           res_rd, res_wr, res_addr, res_do, idle
  );

  modport master (
    output r0_req, r0_wr, r0_addr, r0_wdata, r1_req, r1_wr, r1_addr, r1_wdata, res_di,
    input  r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
           res_rd, res_wr, res_addr, res_do, idle
  );
endinterface

// File: rtl/res_arb.sv
// Two-requester arbiter onto the single-port result memory (1-cycle read latency).
// RES_ARB_RR_EN selects round-robin contention; otherwise r0 has fixed priority.
module res_arb #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic     clk,
  input  logic     reset,
  res_arb_if.slave bus
);
  localparam int STAGES = 2;

  logic          win, acc, acc_wr, acc_rd;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  logic          res_rd_q, res_wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] do_q;
  logic [STAGES:1] vld_pipe, id_pipe;
  logic          rv0_q, rv1_q;
  logic [DW-1:0] rd0_q, rd1_q;

  // win = 1 selects r1; only meaningful while some req is high
`ifdef RES_ARB_RR_EN
  logic ptr;
  always_ff @(posedge clk or negedge reset)
    if (!reset)   ptr <= 1'b0;
    else if (acc) ptr <= ~win;
  assign win = bus.r1_req & (~bus.r0_req | ptr);
`else
  assign win = bus.r1_req & ~bus.r0_req;
`endif

  assign bus.r0_gnt = reset & bus.r0_req & ~win;
  assign bus.r1_gnt = reset & win;
  assign acc        = bus.r0_gnt | bus.r1_gnt;

  always_comb begin
    acc_wr    = bus.r0_wr;
    acc_addr  = bus.r0_addr;
    acc_wdata = bus.r0_wdata;
    if (win) begin
      acc_wr    = bus.r1_wr;
      acc_addr  = bus.r1_addr;
      acc_wdata = bus.r1_wdata;
    end
  end
  assign acc_rd = acc & ~acc_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_rd_q <= 1'b0;
      res_wr_q <= 1'b0;
      addr_q   <= '0;
      do_q     <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      res_rd_q <= acc_rd;
      res_wr_q <= acc & acc_wr;
      if (acc) begin
        addr_q <= acc_addr;
        do_q   <= acc_wdata;
      end
      // stage 1 rides with res_rd, stage 2 with the memory's data cycle
      vld_pipe <= {vld_pipe[STAGES-1:1], acc_rd};
      id_pipe  <= {id_pipe[STAGES-1:1], win};
      rv0_q    <= vld_pipe[STAGES] & ~id_pipe[STAGES];
      rv1_q    <= vld_pipe[STAGES] &  id_pipe[STAGES];
      if (vld_pipe[STAGES] & ~id_pipe[STAGES]) rd0_q <= bus.res_di;
      if (vld_pipe[STAGES] &  id_pipe[STAGES]) rd1_q <= bus.res_di;
    end
  end

  assign bus.res_rd    = res_rd_q;
  assign bus.res_wr    = res_wr_q;
  assign bus.res_addr  = addr_q;
  assign bus.res_do    = do_q;
  assign bus.r0_rvalid = rv0_q;
  assign bus.r1_rvalid = rv1_q;
  assign bus.r0_rdata  = rd0_q;
  assign bus.r1_rdata  = rd1_q;
  assign bus.idle      = ~(res_rd_q | res_wr_q | (|vld_pipe));
endmodule

// File: tb/tb_res_arb.sv
// Bench for res_arb: directed vector table, reset corner sequences and random
// traffic checked against a transaction-level model with its own memory image.
module tb_res_arb;
  localparam int AW = 14;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  res_arb_if #(.AW(AW), .DW(DW)) bus();
  res_arb #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [7:0] init_val(input logic [13:0] a);
    case (a)
      14'h0005: init_val = 8'h3C;
      14'h0010: init_val = 8'h01;
      14'h0011: init_val = 8'h02;
      default:  init_val = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // memory device: one-cycle read latency
  logic [7:0] dmem [16384];
  logic [7:0] rdq;
  bit         mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16384; i++) dmem[i] <= init_val(14'(i));
      mem_init <= 1'b1;
    end else begin
      if (bus.res_wr) dmem[bus.res_addr] <= bus.res_do;
      if (bus.res_rd) rdq <= dmem[bus.res_addr];
    end
  end
  assign bus.res_di = rdq;

  typedef struct {
    bit         q0, w0;
    logic [13:0] a0;
    logic [7:0]  d0;
    bit         q1, w1;
    logic [13:0] a1;
    logic [7:0]  d1;
    bit         eg0, eg1;
    bit         chk_rv;
    logic [1:0] rv;
    logic [7:0] rdat;
  } vec_t;

  typedef struct {
    int         due;
    bit         id;
    logic [7:0] data;
  } ret_t;

  int n_chk = 0, n_fail = 0, cyc = 0;

  // model state
  logic [7:0]  mm [16384];
  ret_t        q[$];
  bit          m_rd, m_wr, favour;
  logic [13:0] m_addr;
  logic [7:0]  m_do, m_rdata0, m_rdata1;

  function automatic vec_t mk(bit q0, bit w0, logic [13:0] a0, logic [7:0] d0,
                              bit q1, bit w1, logic [13:0] a1, logic [7:0] d1,
                              bit eg0, bit eg1, bit cr, logic [1:0] rv, logic [7:0] rdat);
    vec_t v;
    v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.chk_rv = cr; v.rv = rv; v.rdat = rdat;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd = 0; m_wr = 0; favour = 0;
    m_addr = '0; m_do = '0; m_rdata0 = '0; m_rdata1 = '0;
  endtask

  // hold reset low for n cycles with r0 requesting; everything must stay quiet
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      reset = 1'b0;
      bus.r0_req = 1'b1; bus.r0_wr = 1'b0; bus.r1_req = 1'b1; bus.r1_wr = 1'b1;
      model_reset();
      #3;
      check("rst_gnt",    {bus.r0_gnt, bus.r1_gnt}, 0);
      check("rst_rdwr",   {bus.res_rd, bus.res_wr}, 0);
      check("rst_idle",   bus.idle, 1);
      check("rst_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 0);
      check("rst_addr",   bus.res_addr, 0);
      check("rst_do",     bus.res_do, 0);
      check("rst_rdata",  {bus.r0_rdata, bus.r1_rdata}, 0);
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic step(input vec_t v, input bit chk_tab);
    bit eg0, eg1, win, acc, wr, ev0, ev1;
    logic [13:0] a;
    #1;
    reset = 1'b1;
    bus.r0_req = v.q0; bus.r0_wr = v.w0; bus.r0_addr = v.a0; bus.r0_wdata = v.d0;
    bus.r1_req = v.q1; bus.r1_wr = v.w1; bus.r1_addr = v.a1; bus.r1_wdata = v.d1;
    #3;
    if (v.q0 && v.q1) begin
`ifdef RES_ARB_RR_EN
      win = favour;
`else
      win = 1'b0;
`endif
    end else win = v.q1;
    acc = v.q0 | v.q1;
    eg0 = acc & ~win;
    eg1 = acc & win;
    check("gnt0", bus.r0_gnt, eg0);
    check("gnt1", bus.r1_gnt, eg1);
    check("res_rd", bus.res_rd, m_rd);
    check("res_wr", bus.res_wr, m_wr);
    check("res_addr", bus.res_addr, m_addr);
    check("res_do", bus.res_do, m_do);
    ev0 = q.size() > 0 && q[0].due == cyc && !q[0].id;
    ev1 = q.size() > 0 && q[0].due == cyc &&  q[0].id;
    if (ev0) m_rdata0 = q[0].data;
    if (ev1) m_rdata1 = q[0].data;
    if (ev0 || ev1) void'(q.pop_front());
    check("rvalid0", bus.r0_rvalid, ev0);
    check("rvalid1", bus.r1_rvalid, ev1);
    check("rdata0", bus.r0_rdata, m_rdata0);
    check("rdata1", bus.r1_rdata, m_rdata1);
    check("idle", bus.idle, !(m_rd || m_wr || q.size() > 0));
    if (chk_tab) begin
      check("tab_gnt", {bus.r1_gnt, bus.r0_gnt}, {v.eg1, v.eg0});
      if (v.chk_rv) begin
        check("tab_rvalid", {bus.r1_rvalid, bus.r0_rvalid}, v.rv);
        if (v.rv[0]) check("tab_rdata0", bus.r0_rdata, v.rdat);
        if (v.rv[1]) check("tab_rdata1", bus.r1_rdata, v.rdat);
      end
    end
    @(posedge clk);
    if (m_wr) mm[m_addr] = m_do;   // write lands at the end of its res_wr cycle
    wr = win ? v.w1 : v.w0;
    a  = win ? v.a1 : v.a0;
    m_rd = acc & ~wr;
    m_wr = acc & wr;
    if (acc) begin
      m_addr = a;
      m_do   = win ? v.d1 : v.d0;
      favour = ~win;
      if (!wr) q.push_back('{due: cyc + 3, id: win, data: mm[a]});
    end
    cyc++;
  endtask

  vec_t tab[20];
  vec_t nop;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.r0_req = 0; bus.r0_wr = 0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 0; bus.r1_wr = 0; bus.r1_addr = '0; bus.r1_wdata = '0;
    for (int i = 0; i < 16384; i++) mm[i] = init_val(14'(i));
    model_reset();
    nop = mk(0,0,0,0, 0,0,0,0, 0,0, 0,2'b00,0);

    tab[0]  = mk(0,0,14'h0000,0,    1,0,14'h0005,0, 0,1, 0,2'b00,8'h00);
    tab[1]  = nop;
    tab[2]  = nop;
    tab[3]  = mk(1,1,14'h3FFF,8'h7F, 0,0,0,0,       1,0, 1,2'b10,8'h3C);
    tab[4]  = mk(1,0,14'h3FFF,0,    0,0,0,0,        1,0, 0,2'b00,8'h00);
    tab[5]  = nop;
    tab[6]  = nop;
    tab[7]  = mk(1,0,14'h0010,0,    0,0,0,0,        1,0, 1,2'b01,8'h7F);
    tab[8]  = mk(0,0,0,0,           1,0,14'h0011,0, 0,1, 0,2'b00,8'h00);
    tab[9]  = nop;
    tab[10] = mk(0,0,0,0, 0,0,0,0, 0,0, 1,2'b01,8'h01);
    for (int k = 0; k < 6; k++) begin
`ifdef RES_ARB_RR_EN
      tab[11+k] = mk(1,0,14'h0020,0, 1,0,14'h0021,0, (k % 2) == 0, (k % 2) == 1, 0,2'b00,0);
`else
      tab[11+k] = mk(1,0,14'h0020,0, 1,0,14'h0021,0, 1, 0, 0,2'b00,0);
`endif
    end
    tab[11].chk_rv = 1; tab[11].rv = 2'b10; tab[11].rdat = 8'h02;
    tab[12].chk_rv = 1; tab[12].rv = 2'b00;
    for (int k = 17; k < 20; k++) tab[k] = nop;

    @(posedge clk);
    do_reset(3);
    // first edge after release accepts r0
    step(mk(1,0,14'h0010,0, 0,0,0,0, 1,0, 0,2'b00,0), 1);
    for (int i = 0; i < 20; i++) step(tab[i], 1);

    // read accepted, then reset one cycle later drops it
    step(mk(1,0,14'h0005,0, 0,0,0,0, 1,0, 0,2'b00,0), 1);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      step(nop, 0);
      check("drop_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 0);
      check("drop_idle", bus.idle, 1);
    end

    for (int i = 0; i < 400; i++) begin
      vec_t v;
      if ($urandom_range(0, 99) == 0) do_reset(1);
      v = nop;
      v.q0 = 1'($urandom_range(0, 1)); v.w0 = 1'($urandom_range(0, 1));
      v.q1 = 1'($urandom_range(0, 1)); v.w1 = 1'($urandom_range(0, 1));
      v.a0 = 14'($urandom_range(0, 15)); v.a1 = 14'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v.a0 = 14'h3FF0 | v.a0;
      v.d0 = 8'($urandom); v.d1 = 8'($urandom);
      step(v, 0);
    end
    for (int i = 0; i < 4; i++) step(nop, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/res_arb.md
RES_ARB -- requirements
Module: res_arb

Interface
REQ-001 The module SHALL have parameter AW, default 14, meaning res memory address width (128x128 result image).
REQ-002 The module SHALL have parameter DW, default 8, meaning res memory data width.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have ports r0_req/r1_req, input, 1, requester n wants one access this cycle.
REQ-006 The module SHALL have ports r0_wr/r1_wr, input, 1, access type: 1 write, 0 read.
REQ-007 The module SHALL have ports r0_addr/r1_addr, input, AW, and r0_wdata/r1_wdata, input, DW, for the access.
REQ-008 The module SHALL have ports r0_gnt/r1_gnt, output, 1, combinational grant; access accepted on an edge where req and gnt are both 1.
REQ-009 The module SHALL have ports r0_rvalid/r1_rvalid, output, 1, and r0_rdata/r1_rdata, output, DW, for read return.
REQ-010 The module SHALL have memory-side ports res_rd, res_wr, output, 1; res_addr, output, AW; res_do, output, DW; res_di, input, DW.
REQ-011 The module SHALL have port idle, output, 1, high when no access is issued and no read is in flight.

Function
REQ-012 At most one gnt SHALL be high in any cycle; gnt SHALL never be high for a requester whose req is low.
REQ-013 A single requesting requester SHALL be granted in the same cycle (no bubble).
REQ-014 When both request, the winner SHALL be chosen by the priority rule in REQ-027/REQ-028.
REQ-015 On an accept edge the winner's addr/wdata/type SHALL be registered onto res_addr/res_do and exactly one of res_rd/res_wr, high for exactly one cycle.
REQ-016 In cycles with no accepted access, res_rd and res_wr SHALL be 0; res_addr and res_do SHALL hold their last values.
REQ-017 Memory read latency is one cycle: res_di SHALL be sampled at the edge ending the cycle after res_rd was high.
REQ-018 Sampled data SHALL appear on the issuing requester's rdata with its rvalid high for exactly one cycle: accept edge E0, res_rd in E0-E1, sample at E2, rvalid in E2-E3.
REQ-019 A two-stage requester-ID pipeline SHALL route each read return; returns SHALL be in issue order. Throughput is one access per cycle.
REQ-020 rdata SHALL hold its value when rvalid is low.
REQ-021 A write followed back-to-back by a read to the same address SHALL return the written data. Strict in-order issue on the single port guarantees this.
REQ-022 idle SHALL be low while res_rd, res_wr, or either ID-pipeline valid stage is set.

Reset
REQ-023 While reset is low, res_rd, res_wr, r0_rvalid and r1_rvalid SHALL be 0. res_addr, res_do, r0_rdata and r1_rdata SHALL be 0. idle SHALL be 1. The round-robin pointer SHALL favour r0.
REQ-024 Reset asserted mid-operation SHALL drop in-flight reads; no rvalid SHALL appear for them after release.
REQ-025 gnt SHALL be 0 during reset regardless of req.
REQ-026 The first edge after reset release SHALL be able to accept an access.

Configuration
REQ-027 With RES_ARB_RR_EN defined, contention SHALL be resolved round-robin. The pointer SHALL move to the other requester after each accepted access, so under continuous dual requests grants alternate r0, r1, r0, ...
REQ-028 Without RES_ARB_RR_EN, contention SHALL be resolved by fixed priority with r0 always winning; the pointer logic SHALL be absent.

Verification
REQ-029 Reset low with r0_req=1 -> all gnt=0, res_rd=res_wr=0, idle=1; after release r0 granted on first edge.
REQ-030 r1 alone reads addr 0x0005 holding 0x3C -> r1_gnt same cycle, res_rd=1 with res_addr=0x0005 next cycle, r1_rvalid=1 with r1_rdata=0x3C two cycles after accept, r0_rvalid stays 0.
REQ-031 r0 writes 0x7F to 0x3FFF then reads 0x3FFF back-to-back -> res_wr then res_rd in consecutive cycles, r0_rdata=0x7F.
REQ-032 Both requesters hold req high for 6 cycles -> with RES_ARB_RR_EN grants r0,r1,r0,r1,r0,r1; without it r0 ×6 and r1 starved.
REQ-033 Interleaved reads r0@0x0010 (data 0x01), r1@0x0011 (data 0x02) on consecutive edges -> r0_rvalid/0x01 then r1_rvalid/0x02 on consecutive cycles.
REQ-034 Reset pulsed one cycle after a read accept -> no rvalid afterwards, idle=1.
